mc_ctrl: RTL and testbench

Multi-cycle main controller for the P5 MIPS datapath. It sequences one instruction at a time through FETCH/DECODE/EXE/MEM/WB. From the latched instruction and the ALU zero flag it generates every write enable and mux select, including the NPC jump/branch select and the PC source. Supported set: addu, subu, jr, ori, lw, sw, beq, lui, j, jal; every other encoding, including the all-zero nop, retires as a no-op.

---
 rtl/mc_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle main controller for the P5 MIPS datapath. Steps one
//            instruction through FETCH/DECODE/EXE/MEM/WB and derives every
//            write enable and mux select from the latched instruction.
// Revision : 1.0  initial release
// ============================================================================
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic [2:0]  State,
  output logic        PCWr,
  output logic [1:0]  PCSel,
  output logic        NPCOp,
  output logic        IRWr,
  output logic        RegWr,
  output logic [1:0]  RegDst,
  output logic [1:0]  WDSel,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        EXTOp,
  output logic        MemWr,
  output logic        Retire
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [5:0] op, funct;
  logic       is_rtype, is_addu, is_subu, is_jr;
  logic       is_ori, is_lw, is_sw, is_beq, is_lui, is_j, is_jal;
  logic       is_zero, is_legal;
  logic       alu_src, ext_op;
  logic [1:0] alu_op;

  assign op       = Instr[31:26];
  assign funct    = Instr[5:0];
  assign is_rtype = (op == 6'b000000);
  assign is_addu  = is_rtype && (funct == 6'b100001);
  assign is_subu  = is_rtype && (funct == 6'b100011);
  assign is_jr    = is_rtype && (funct == 6'b001000);
  assign is_ori   = (op == 6'b001101);
  assign is_lw    = (op == 6'b100011);
  assign is_sw    = (op == 6'b101011);
  assign is_beq   = (op == 6'b000100);
  assign is_lui   = (op == 6'b001111);
  assign is_j     = (op == 6'b000010);
  assign is_jal   = (op == 6'b000011);
  // The all-zero word decodes as sll, which is unsupported anyway; the
  // explicit compare keeps the nop case obvious to the reader.
  assign is_zero  = (Instr == 32'd0);
  assign is_legal = !is_zero && (is_addu || is_subu || is_jr || is_ori || is_lw ||
                                 is_sw || is_beq || is_lui || is_j || is_jal);

  // ALU controls shared by EXE, MEM and WB so the ALU result stays stable.
  assign alu_src = is_ori || is_lui || is_lw || is_sw;
  assign ext_op  = is_lw || is_sw || is_beq;
  assign alu_op  = (is_subu || is_beq) ? 2'b01 :
                   is_ori              ? 2'b10 :
                   is_lui              ? 2'b11 : 2'b00;

  assign State = state_q;

  // State register; reset returns to FETCH from any state.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and output decode; enables are suppressed while reset is high.
  always_comb begin
    state_d = S_FETCH;
    PCWr    = 1'b0;
    PCSel   = 2'b00;
    NPCOp   = 1'b0;
    IRWr    = 1'b0;
    RegWr   = 1'b0;
    RegDst  = 2'b00;
    WDSel   = 2'b00;
    ALUSrc  = 1'b0;
    ALUOp   = 2'b00;
    EXTOp   = 1'b0;
    MemWr   = 1'b0;
    Retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWr    = 1'b1;
        PCWr    = 1'b1;
        PCSel   = 2'b00;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_j || is_jal) begin
          PCWr   = 1'b1;
          PCSel  = 2'b01;
          NPCOp  = 1'b1;
          Retire = 1'b1;
          if (is_jal) begin
            RegWr  = 1'b1;
            RegDst = 2'b10;
            WDSel  = 2'b10;
          end
        end else if (is_jr) begin
          PCWr   = 1'b1;
          PCSel  = 2'b10;
          Retire = 1'b1;
        end else if (!is_legal) begin
          Retire = 1'b1;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        ALUSrc = alu_src;
        EXTOp  = ext_op;
        ALUOp  = alu_op;
        if (is_beq) begin
          NPCOp  = 1'b0;
          PCSel  = 2'b01;
          PCWr   = Zero;
          Retire = 1'b1;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        ALUSrc = alu_src;
        EXTOp  = ext_op;
        ALUOp  = alu_op;
        if (is_sw) begin
          MemWr  = 1'b1;
          Retire = 1'b1;
        end else if (is_lw) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        ALUSrc = alu_src;
        EXTOp  = ext_op;
        ALUOp  = alu_op;
        RegWr  = 1'b1;
        Retire = 1'b1;
        RegDst = (is_addu || is_subu) ? 2'b01 : 2'b00;
        WDSel  = is_lw ? 2'b01 : 2'b00;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      PCWr   = 1'b0;
      IRWr   = 1'b0;
      RegWr  = 1'b0;
      MemWr  = 1'b0;
      Retire = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl
// Purpose  : Directed self-checking bench for mc_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic        Zero;
  logic [2:0]  State;
  logic        PCWr, NPCOp, IRWr, RegWr, ALUSrc, EXTOp, MemWr, Retire;
  logic [1:0]  PCSel, RegDst, WDSel, ALUOp;

  int n_checks = 0;
  int n_fail   = 0;

  mc_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .Instr  (Instr),
    .Zero   (Zero),
    .State  (State),
    .PCWr   (PCWr),
    .PCSel  (PCSel),
    .NPCOp  (NPCOp),
    .IRWr   (IRWr),
    .RegWr  (RegWr),
    .RegDst (RegDst),
    .WDSel  (WDSel),
    .ALUSrc (ALUSrc),
    .ALUOp  (ALUOp),
    .EXTOp  (EXTOp),
    .MemWr  (MemWr),
    .Retire (Retire)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed enables {PCWr, IRWr, RegWr, MemWr, Retire}.
  function automatic logic [4:0] ens();
    return {PCWr, IRWr, RegWr, MemWr, Retire};
  endfunction

  // Present an instruction while in FETCH, check FETCH outputs, move to DECODE.
  task automatic fetch(input string tag, input logic [31:0] ins);
    Instr = ins;
    #1;
    check_eq({tag, ".fetch_state"}, State, 0);
    check_eq({tag, ".fetch_ens"}, ens(), 5'b11000);
    check_eq({tag, ".fetch_pcsel"}, PCSel, 0);
    step();
    check_eq({tag, ".decode_state"}, State, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    Instr = 32'h8C00_0000;
    Zero  = 1'b0;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_state", State, 0);
      check_eq("rst_ens", ens(), 0);
    end
    reset = 1'b0;
    #1;
    check_eq("rel_ens", ens(), 5'b11000);
    check_eq("rel_pcsel", PCSel, 0);

    // lw: 0,1,2,3,4,0
    fetch("lw", 32'h8C22_0004);
    check_eq("lw.dec_ens", ens(), 0);
    step();
    check_eq("lw.exe_state", State, 2);
    check_eq("lw.exe_alu", {ALUSrc, EXTOp, ALUOp}, 4'b1100);
    check_eq("lw.exe_ens", ens(), 0);
    step();
    check_eq("lw.mem_state", State, 3);
    check_eq("lw.mem_ens", ens(), 0);
    check_eq("lw.mem_alu", {ALUSrc, EXTOp, ALUOp}, 4'b1100);
    step();
    check_eq("lw.wb_state", State, 4);
    check_eq("lw.wb_ens", ens(), 5'b00101);
    check_eq("lw.wb_sel", {RegDst, WDSel}, 4'b0001);
    step();
    check_eq("lw.end_state", State, 0);

    // beq taken
    fetch("beq1", 32'h1022_0003);
    Zero = 1'b1;
    step();
    check_eq("beq1.exe_state", State, 2);
    check_eq("beq1.exe_ens", ens(), 5'b10001);
    check_eq("beq1.exe_sel", {PCSel, NPCOp}, 3'b010);
    check_eq("beq1.exe_alu", {ALUSrc, EXTOp, ALUOp}, 4'b0101);
    step();
    check_eq("beq1.end_state", State, 0);

    // beq not taken
    Zero = 1'b0;
    fetch("beq0", 32'h1022_0003);
    step();
    check_eq("beq0.exe_ens", ens(), 5'b00001);
    step();
    check_eq("beq0.end_state", State, 0);

    // jal
    fetch("jal", 32'h0C00_0C10);
    check_eq("jal.dec_ens", ens(), 5'b10101);
    check_eq("jal.dec_sel", {PCSel, NPCOp, RegDst, WDSel}, 7'b01_1_10_10);
    step();
    check_eq("jal.end_state", State, 0);

    // j
    fetch("j", 32'h0800_0010);
    check_eq("j.dec_ens", ens(), 5'b10001);
    check_eq("j.dec_sel", {PCSel, NPCOp}, 3'b011);
    step();
    check_eq("j.end_state", State, 0);

    // jr
    fetch("jr", 32'h03E0_0008);
    check_eq("jr.dec_ens", ens(), 5'b10001);
    check_eq("jr.dec_pcsel", PCSel, 2'b10);
    step();
    check_eq("jr.end_state", State, 0);

    // subu: 4 cycles
    fetch("subu", 32'h0043_2023);
    step();
    check_eq("subu.exe_state", State, 2);
    check_eq("subu.exe_alu", {ALUSrc, EXTOp, ALUOp}, 4'b0001);
    step();
    check_eq("subu.wb_state", State, 4);
    check_eq("subu.wb_ens", ens(), 5'b00101);
    check_eq("subu.wb_sel", {RegDst, WDSel}, 4'b0100);
    step();
    check_eq("subu.end_state", State, 0);

    // ori
    fetch("ori", 32'h3442_0001);
    step();
    check_eq("ori.exe_alu", {ALUSrc, EXTOp, ALUOp}, 4'b1010);
    step();
    check_eq("ori.wb_sel", {RegDst, WDSel}, 4'b0000);
    check_eq("ori.wb_ens", ens(), 5'b00101);
    step();
    check_eq("ori.end_state", State, 0);

    // lui
    fetch("lui", 32'h3C01_1234);
    step();
    check_eq("lui.exe_alu", {ALUSrc, EXTOp, ALUOp}, 4'b1011);
    step();
    check_eq("lui.wb_state", State, 4);
    step();
    check_eq("lui.end_state", State, 0);

    // all-zero nop
    fetch("nop", 32'h0000_0000);
    check_eq("nop.dec_ens", ens(), 5'b00001);
    step();
    check_eq("nop.end_state", State, 0);

    // sw with reset asserted in MEM
    fetch("sw", 32'hAC22_0000);
    step();
    check_eq("sw.exe_state", State, 2);
    step();
    check_eq("sw.mem_state", State, 3);
    check_eq("sw.mem_ens", ens(), 5'b00011);
    reset = 1'b1;
    #1;
    check_eq("sw.rst_ens", ens(), 0);
    step();
    check_eq("sw.rst_state", State, 0);
    reset = 1'b0;
    #1;
    check_eq("sw.rel_ens", ens(), 5'b11000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
